// File: rtl/dmux_deser4_pkg.sv
// dmux_pkg: shared definitions for the dmux_deser4 deserializer.
//   NCH      - number of demux channels (y0..y3)
//   ch_sel_t - channel select type matching the demux sel input
//   chan_mask - one-hot mask of a channel select
package dmux_pkg;

   localparam int NCH = 4;

   typedef logic [1:0] ch_sel_t;

   // One-hot mask for a channel; used for enable decode and steering check.
   function automatic logic [NCH-1:0] chan_mask(input ch_sel_t c);
      logic [NCH-1:0] m;
      m = '0;
      m[c] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/dmux_deser4_lane.sv
// deser_lane: one channel of the 1:4 demux deserializer.
// Shifts in serial bits MSB-first, emits a WIDTH-bit word over a
// valid/ready handshake and flags a sticky overflow when a word completes
// while the previous one is still held un-accepted.
// Ports:
//   clk, rst  - clock, async active-high reset
//   en        - this lane owns the bit sampled this cycle
//   sync      - frame sync, restarts bit counting
//   bit_in    - serial bit for this lane (valid when en=1)
//   rdy       - consumer ready
//   err_clr   - clear sticky overflow
//   vld, data - word valid / held word
//   ovf       - sticky overflow
module deser_lane #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             bit_in,
   input  logic             rdy,
   input  logic             err_clr,
   output logic             vld,
   output logic [WIDTH-1:0] data,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;

   // sync acts before the capture, so a bit arriving with sync becomes
   // bit 0 of a fresh word.
   logic [WIDTH-1:0] shreg_base;
   logic [CNT_W-1:0] cnt_base;
   logic [WIDTH-1:0] word;
   logic             done;
   logic             load;
   logic             accept;

   always_comb begin
      shreg_base = sync ? '0 : shreg;
      cnt_base   = sync ? '0 : cnt;
      word       = {shreg_base[WIDTH-2:0], bit_in};
      done       = en && (cnt_base == LAST);
      accept     = vld && rdy;
      // A completed word lands only if the holding register is free or
      // is being emptied on this same edge.
      load       = done && (!vld || rdy);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (en) begin
         shreg <= word;
         cnt   <= done ? '0 : cnt_base + 1'b1;
      end else begin
         shreg <= shreg_base;
         cnt   <= cnt_base;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld  <= 1'b0;
         data <= '0;
      end else if (load) begin
         vld  <= 1'b1;
         data <= word;
      end else if (accept) begin
         vld  <= 1'b0;
      end
   end

   // Set wins over clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf <= 1'b0;
      else if (done && vld && !rdy)
         ovf <= 1'b1;
      else if (err_clr)
         ovf <= 1'b0;
   end

endmodule

// File: rtl/dmux_deser4.sv
// dmux_deser4: downstream stage of a 1:4 bit demultiplexer.
// Captures the bit steered onto y[sel] into a per-channel WIDTH-bit word
// and presents each word over its own valid/ready handshake.
// Ports:
//   clk, rst           - clock, async active-high reset
//   bit_vld, sel       - a bit is live on y[sel] this cycle
//   y0..y3             - demux outputs
//   sync               - frame sync, restarts bit counting on all channels
//   out_vld, out_rdy   - per-channel handshake
//   out_data           - channel c word at [c*WIDTH +: WIDTH]
//   ovf                - per-channel sticky overflow
//   steer_err          - sticky: activity on a non-selected y line
//   err_clr            - clears ovf and steer_err
module dmux_deser4
   import dmux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bit_vld,
   input  ch_sel_t              sel,
   input  logic                 y0,
   input  logic                 y1,
   input  logic                 y2,
   input  logic                 y3,
   input  logic                 sync,
   output logic [NCH-1:0]       out_vld,
   input  logic [NCH-1:0]       out_rdy,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic [NCH-1:0]       ovf,
   output logic                 steer_err,
   input  logic                 err_clr
);

   logic [NCH-1:0] y_vec;
   logic [NCH-1:0] sel_mask;
   logic [NCH-1:0] lane_en;
   logic           bit_sel;
   logic           steer_set;

   always_comb begin
      y_vec     = {y3, y2, y1, y0};
      sel_mask  = chan_mask(sel);
      lane_en   = bit_vld ? sel_mask : '0;
      bit_sel   = y_vec[sel];
      // Only meaningful while a bit is live; idle y lines are don't-care.
      steer_set = bit_vld && |(y_vec & ~sel_mask);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         steer_err <= 1'b0;
      else if (steer_set)
         steer_err <= 1'b1;
      else if (err_clr)
         steer_err <= 1'b0;
   end

   for (genvar c = 0; c < NCH; c++) begin : g_lane
      deser_lane #(.WIDTH(WIDTH)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .en      (lane_en[c]),
         .sync    (sync),
         .bit_in  (bit_sel),
         .rdy     (out_rdy[c]),
         .err_clr (err_clr),
         .vld     (out_vld[c]),
         .data    (out_data[c*WIDTH +: WIDTH]),
         .ovf     (ovf[c])
      );
   end

endmodule

// File: tb/tb_dmux_deser4.sv
module tb_dmux_deser4;

   logic        clk;
   logic        rst;
   logic        bit_vld;
   logic [1:0]  sel;
   logic        y0, y1, y2, y3;
   logic        sync;
   logic [3:0]  out_vld;
   logic [3:0]  out_rdy;
   logic [31:0] out_data;
   logic [3:0]  ovf;
   logic        steer_err;
   logic        err_clr;

   int total = 0;
   int bad   = 0;

   dmux_deser4 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bit_vld   (bit_vld),
      .sel       (sel),
      .y0        (y0),
      .y1        (y1),
      .y2        (y2),
      .y3        (y3),
      .sync      (sync),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out_data  (out_data),
      .ovf       (ovf),
      .steer_err (steer_err),
      .err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   // Drive one live bit on channel ch plus any extra y lines, then return
   // inputs to idle.
   task automatic send_bit(input logic [1:0] ch, input logic b, input logic [3:0] extra);
      logic [3:0] yv;
      yv = extra;
      if (b) yv[ch] = 1'b1;
      bit_vld = 1'b1;
      sel = ch;
      {y3, y2, y1, y0} = yv;
      clk_step();
      bit_vld = 1'b0;
      {y3, y2, y1, y0} = 4'b0000;
      sync = 1'b0;
      err_clr = 1'b0;
   endtask

   // Send bits w[hi] down to w[lo] on channel ch.
   task automatic send_bits(input logic [1:0] ch, input logic [7:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) send_bit(ch, w[i], 4'b0000);
   endtask

   initial begin
      logic [7:0] a, b;
      rst = 1'b1; bit_vld = 1'b0; sel = 2'd0; {y3, y2, y1, y0} = 4'b0000;
      sync = 1'b0; out_rdy = 4'h0; err_clr = 1'b0;
      clk_step();
      chk("rst_vld",   {28'd0, out_vld}, 32'h0);
      chk("rst_data",  out_data, 32'h0);
      chk("rst_ovf",   {28'd0, ovf}, 32'h0);
      chk("rst_steer", {31'd0, steer_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      clk_step();

      // 1: channel 2 word 0xB2, consumer not ready
      a = 8'hB2;
      send_bits(2'd2, a, 7, 1);
      chk("t1_vld_before", {28'd0, out_vld}, 32'h0);
      send_bits(2'd2, a, 0, 0);
      chk("t1_vld",  {28'd0, out_vld}, 32'h4);
      chk("t1_data", out_data, 32'h00B2_0000);
      out_rdy = 4'b0100;
      clk_step();
      chk("t1_accept_vld",  {28'd0, out_vld}, 32'h0);
      chk("t1_accept_data", out_data, 32'h00B2_0000);

      // 2: interleave ch0 0x5A and ch3 0xC3, all ready
      out_rdy = 4'hF;
      a = 8'h5A; b = 8'hC3;
      for (int i = 7; i >= 1; i--) begin
         send_bit(2'd0, a[i], 4'b0000);
         send_bit(2'd3, b[i], 4'b0000);
      end
      chk("t2_vld_mid", {28'd0, out_vld}, 32'h0);
      send_bit(2'd0, a[0], 4'b0000);
      chk("t2_vld0",  {28'd0, out_vld}, 32'h1);
      chk("t2_data0", out_data, 32'h00B2_005A);
      send_bit(2'd3, b[0], 4'b0000);
      chk("t2_vld3",  {28'd0, out_vld}, 32'h8);
      chk("t2_data3", out_data, 32'hC3B2_005A);
      clk_step();
      chk("t2_vld_idle", {28'd0, out_vld}, 32'h0);

      // 3: overflow on channel 1
      out_rdy = 4'b1101;
      send_bits(2'd1, 8'h11, 7, 0);
      chk("t3_vld1",  {28'd0, out_vld}, 32'h2);
      chk("t3_data1", out_data, 32'hC3B2_115A);
      chk("t3_ovf0",  {28'd0, ovf}, 32'h0);
      send_bits(2'd1, 8'h22, 7, 0);
      chk("t3_ovf1",      {28'd0, ovf}, 32'h2);
      chk("t3_hold_data", out_data, 32'hC3B2_115A);
      chk("t3_hold_vld",  {28'd0, out_vld}, 32'h2);
      out_rdy = 4'hF;
      clk_step();
      chk("t3_drain_vld", {28'd0, out_vld}, 32'h0);
      chk("t3_ovf_kept",  {28'd0, ovf}, 32'h2);
      err_clr = 1'b1;
      clk_step();
      err_clr = 1'b0;
      chk("t3_ovf_clr", {28'd0, ovf}, 32'h0);

      // 4: completion coinciding with acceptance on channel 0
      out_rdy = 4'b1110;
      send_bits(2'd0, 8'h3C, 7, 0);
      chk("t4_vld_a",  {28'd0, out_vld}, 32'h1);
      chk("t4_data_a", out_data, 32'hC3B2_113C);
      a = 8'h96;
      send_bits(2'd0, a, 7, 1);
      chk("t4_hold", out_data, 32'hC3B2_113C);
      out_rdy = 4'hF;
      send_bit(2'd0, a[0], 4'b0000);
      chk("t4_vld_b",  {28'd0, out_vld}, 32'h1);
      chk("t4_data_b", out_data, 32'hC3B2_1196);
      chk("t4_ovf",    {28'd0, ovf}, 32'h0);
      clk_step();
      chk("t4_vld_idle", {28'd0, out_vld}, 32'h0);

      // 5: sync restarts channel 2 mid-word
      send_bits(2'd2, 8'hFF, 4, 0);
      a = 8'hA5;
      sync = 1'b1;
      send_bit(2'd2, a[7], 4'b0000);
      send_bits(2'd2, a, 6, 1);
      chk("t5_vld_before", {28'd0, out_vld}, 32'h0);
      chk("t5_data_before", out_data, 32'hC3B2_1196);
      send_bits(2'd2, a, 0, 0);
      chk("t5_vld",  {28'd0, out_vld}, 32'h4);
      chk("t5_data", out_data, 32'hC3A5_1196);
      clk_step();

      // 6: steering error, set-wins clear, async reset mid-word
      out_rdy = 4'b1110;
      chk("t6_steer0", {31'd0, steer_err}, 32'h0);
      send_bit(2'd0, 1'b1, 4'b0010);
      chk("t6_steer_set", {31'd0, steer_err}, 32'h1);
      send_bits(2'd0, 8'h81, 6, 0);
      chk("t6_vld",  {28'd0, out_vld}, 32'h1);
      chk("t6_data", out_data, 32'hC3A5_1181);
      send_bits(2'd0, 8'h42, 7, 0);
      chk("t6_ovf",  {28'd0, ovf}, 32'h1);
      chk("t6_keep", out_data, 32'hC3A5_1181);
      err_clr = 1'b1;
      {y3, y2, y1, y0} = 4'b0110;
      clk_step();
      err_clr = 1'b0;
      {y3, y2, y1, y0} = 4'b0000;
      chk("t6_steer_clr", {31'd0, steer_err}, 32'h0);
      chk("t6_ovf_clr",   {28'd0, ovf}, 32'h0);
      err_clr = 1'b1;
      send_bit(2'd3, 1'b0, 4'b0001);
      chk("t6_set_wins", {31'd0, steer_err}, 32'h1);
      send_bits(2'd1, 8'hE0, 7, 5);
      send_bits(2'd0, 8'h80, 7, 7);
      chk("t6_ovf_again", {28'd0, ovf}, 32'h0);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_async_vld",   {28'd0, out_vld}, 32'h0);
      chk("t6_async_data",  out_data, 32'h0);
      chk("t6_async_ovf",   {28'd0, ovf}, 32'h0);
      chk("t6_async_steer", {31'd0, steer_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      out_rdy = 4'hF;
      send_bits(2'd1, 8'h6B, 7, 1);
      chk("t6_post1_vld_before", {28'd0, out_vld}, 32'h0);
      send_bits(2'd1, 8'h6B, 0, 0);
      chk("t6_post1_vld",  {28'd0, out_vld}, 32'h2);
      chk("t6_post1_data", out_data, 32'h0000_6B00);
      send_bits(2'd3, 8'hF0, 7, 1);
      chk("t6_post3_vld_before", {28'd0, out_vld}, 32'h0);
      send_bits(2'd3, 8'hF0, 0, 0);
      chk("t6_post3_vld",  {28'd0, out_vld}, 32'h8);
      chk("t6_post3_data", out_data, 32'hF000_6B00);
      clk_step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
